quant_scheduler: RTL and testbench
==================================

Name: quant_scheduler

Overview:
Arbitrates one shared 8x8 quantizer between the Y, Cb and Cr component streams. It grants requesters in round-robin order and selects the quantizer's component table. It launches each block with a one-cycle enable and waits for the quantizer's out_enable. It then returns a per-component done pulse, with a watchdog against a stalled pipeline. It sits between the DCT-side block buffers and the quantizer, ahead of zigzag/entropy coding.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before forced completion (>=2)
CNT_W, 16, width of completed-block counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
req  input  3  block-ready requests; bit0 Y, bit1 Cb, bit2 Cr; level, held until matching done
grant  output  3  one-hot owner of quantizer, held from LAUNCH through DONE
sel  output  2  component table select to quantizer: 0 Y, 1 Cb, 2 Cr, 3 idle
q_enable  output  1  one-cycle start pulse to quantizer
q_out_enable  input  1  quantizer result-valid pulse
done  output  3  one-hot one-cycle completion pulse to owning requester
busy  output  1  high whenever state != IDLE
timeout_err  output  1  sticky flag, set on watchdog expiry
blk_count  output  CNT_W  total completed blocks, wraps modulo 2^CNT_W

Behaviour:
- All outputs registered.
- Reset (rst==0 at clk edge), including mid-operation:
  - state IDLE; grant=0, done=0, q_enable=0, busy=0, sel=3.
  - timeout_err=0, blk_count=0, priority pointer=Y, watchdog=0.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE: if req!=0, pick first set bit at or after the pointer, in order Y->Cb->Cr->Y.
  - Next cycle enters LAUNCH with grant=winner, sel=winner code, q_enable=1, busy=1.
  - If req==0, stay in IDLE.
- LAUNCH: lasts exactly one cycle. q_enable falls next cycle; watchdog cleared; go to WAIT.
- WAIT: q_out_enable sampled high -> DONE next cycle.
  - Otherwise watchdog increments.
  - When watchdog reaches TIMEOUT-1 without q_out_enable: set timeout_err, go to DONE.
  - If q_out_enable coincides with the expiry cycle, completion wins and timeout_err is not set.
- DONE: lasts one cycle.
  - done=grant; blk_count+1; pointer=index after winner (Cr->Y).
  - Next cycle: IDLE, grant=0, sel=3, busy=0.
- Latency:
  - req seen in IDLE at cycle n -> grant/q_enable at n+1.
  - q_out_enable at cycle m (in WAIT) -> done at m+1 -> grant low at m+2.
  - Minimum job = 4 cycles + quantizer latency.
- Arbitration occurs only in IDLE. Requests arriving during a job wait. A held request is served at the next IDLE cycle.
- req bit dropped while granted: the job still completes and done still pulses.
- q_out_enable outside WAIT is ignored: no state change, no done.
- grant, done and sel are always mutually consistent. At most one grant bit and at most one done bit are set.
- timeout_err clears only on reset.

Test Plan:
1. req=001 held; quantizer model returns q_out_enable 3 cycles after q_enable -> grant=001 and sel=0 at n+1, single q_enable pulse; done=001 one cycle after q_out_enable; blk_count=1; busy low after.
2. req=111 held for four jobs -> grants in order 001, 010, 100, 001; each done matches its grant; blk_count=4.
3. After one Y job, req=110 -> Cb served first, then Cr; pointer wraps back to Y.
4. Model never answers, TIMEOUT=16 -> done pulses after 16 WAIT cycles; timeout_err=1 and stays 1 through later normal jobs until rst=0.
5. rst driven low during WAIT -> next edge: grant=0, sel=3, busy=0, blk_count=0; late q_out_enable ignored, no done.
6. q_out_enable on the expiry cycle -> normal done, timeout_err remains 0; a stray q_out_enable in IDLE -> no response.

Source files
------------

// File: rtl/quant_scheduler.sv
// quant_scheduler: round-robin Y/Cb/Cr arbiter for a shared quantizer; ports: req/grant/done per component, sel/q_enable/q_out_enable to quantizer, busy, timeout_err, blk_count
module quant_scheduler #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  output logic [2:0]       grant,
  output logic [1:0]       sel,
  output logic             q_enable,
  input  logic             q_out_enable,
  output logic [2:0]       done,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] blk_count
);
  localparam int WD_W = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t state, state_d;
  logic [2:0] grant_d, done_d, idx;
  logic [1:0] sel_d, ptr, ptr_d, win;
  logic q_enable_d, busy_d, timeout_err_d, found;
  logic [CNT_W-1:0] blk_count_d;
  logic [WD_W-1:0] wd, wd_d;
  logic finish;
  always_comb begin
    found = 1'b0;
    win = 2'd0;
    idx = 3'd0;
    for (int i = 0; i < 3; i++) begin
      idx = {1'b0, ptr} + 3'(i);
      idx = idx >= 3'd3 ? idx - 3'd3 : idx;
      if (!found && req[idx[1:0]]) begin
        found = 1'b1;
        win = idx[1:0];
      end
    end
  end
  assign finish = q_out_enable || wd == WD_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state;
    grant_d = grant;
    sel_d = sel;
    q_enable_d = 1'b0;
    done_d = 3'd0;
    busy_d = busy;
    timeout_err_d = timeout_err;
    blk_count_d = blk_count;
    ptr_d = ptr;
    wd_d = wd;
    case (state)
      IDLE: if (found) begin
        state_d = LAUNCH;
        grant_d = 3'b001 << win;
        sel_d = win;
        q_enable_d = 1'b1;
        busy_d = 1'b1;
      end
      LAUNCH: begin
        state_d = WAIT;
        wd_d = '0;
      end
      WAIT: if (finish) begin
        state_d = DONE;
        done_d = grant;
        blk_count_d = blk_count + CNT_W'(1);
        ptr_d = sel == 2'd2 ? 2'd0 : sel + 2'd1;
        timeout_err_d = timeout_err | ~q_out_enable;
      end else begin
        wd_d = wd + WD_W'(1);
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 3'd0;
        sel_d = 2'd3;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= 3'd0;
      sel <= 2'd3;
      q_enable <= 1'b0;
      done <= 3'd0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      blk_count <= '0;
      ptr <= 2'd0;
      wd <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      sel <= sel_d;
      q_enable <= q_enable_d;
      done <= done_d;
      busy <= busy_d;
      timeout_err <= timeout_err_d;
      blk_count <= blk_count_d;
      ptr <= ptr_d;
      wd <= wd_d;
    end
  end
endmodule

// File: tb/tb_quant_scheduler.sv
// tb_quant_scheduler: directed self-checking bench for quant_scheduler
module tb_quant_scheduler;
  logic clk = 1'b0, rst = 1'b0, q_out_enable = 1'b0;
  logic [2:0] req = 3'd0;
  logic [2:0] grant, done;
  logic [1:0] sel;
  logic q_enable, busy, timeout_err;
  logic [15:0] blk_count;
  int total = 0, bad = 0;
  logic [2:0] g, d, d_after;
  logic [1:0] s;
  logic qe_after, busy_after;
  int cycles;
  quant_scheduler #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel), .q_enable(q_enable),
    .q_out_enable(q_out_enable), .done(done), .busy(busy), .timeout_err(timeout_err),
    .blk_count(blk_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    req = 3'd0;
    q_out_enable = 1'b0;
    tick();
    rst = 1'b1;
  endtask
  task automatic do_job(input int lat);
    int n;
    n = 0;
    g = 3'd0; s = 2'd0; d = 3'd0; d_after = 3'd0; qe_after = 1'b1; busy_after = 1'b1; cycles = 0;
    while (!q_enable && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (!q_enable) begin
      bad++;
      $display("FAIL launch_wait: q_enable=%b required=1 within 10 cycles", q_enable);
      return;
    end
    g = grant;
    s = sel;
    tick();
    qe_after = q_enable;
    cycles = 1;
    if (lat >= 0) begin
      while (cycles < lat) begin
        tick();
        cycles++;
      end
      q_out_enable = 1'b1;
      tick();
      cycles++;
      q_out_enable = 1'b0;
    end else begin
      while (done == 3'd0 && cycles < 40) begin
        tick();
        cycles++;
      end
    end
    d = done;
    tick();
    d_after = done;
    busy_after = busy;
  endtask
  task automatic test_reset();
    tick();
    total++;
    if ({grant, sel, q_enable, done, busy, timeout_err, blk_count} !== {3'd0, 2'd3, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL reset: grant=%b sel=%0d qe=%b done=%b busy=%b terr=%b cnt=%0d required 000/3/0/000/0/0/0",
               grant, sel, q_enable, done, busy, timeout_err, blk_count);
    end
    rst = 1'b1;
  endtask
  task automatic test_single();
    req = 3'b001;
    tick();
    total++;
    if (grant !== 3'b001 || sel !== 2'd0 || q_enable !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_launch: grant=%b sel=%0d qe=%b busy=%b required 001/0/1/1", grant, sel, q_enable, busy);
    end
    do_job(3);
    req = 3'd0;
    total++;
    if (qe_after !== 1'b0 || d !== 3'b001 || cycles != 4) begin
      bad++;
      $display("FAIL single_done: qe_after=%b done=%b cycles=%0d required 0/001/4", qe_after, d, cycles);
    end
    total++;
    if (blk_count !== 16'd1 || busy_after !== 1'b0 || d_after !== 3'd0 || grant !== 3'd0 || sel !== 2'd3) begin
      bad++;
      $display("FAIL single_after: cnt=%0d busy=%b done=%b grant=%b sel=%0d required 1/0/000/000/3",
               blk_count, busy_after, d_after, grant, sel);
    end
  endtask
  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      do_job(2);
      total++;
      if (g !== exp_g[i] || d !== exp_g[i] || s !== 2'(i % 3)) begin
        bad++;
        $display("FAIL rr_job%0d: grant=%b done=%b sel=%0d required %b/%b/%0d", i, g, d, s, exp_g[i], exp_g[i], i % 3);
      end
    end
    req = 3'd0;
    total++;
    if (blk_count !== 16'd4) begin
      bad++;
      $display("FAIL rr_count: cnt=%0d required 4", blk_count);
    end
  endtask
  task automatic test_pointer_wrap();
    logic [2:0] reqs [4];
    logic [2:0] exp_g [4];
    reqs = '{3'b001, 3'b110, 3'b100, 3'b011};
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = reqs[i];
      do_job(1);
      total++;
      if (g !== exp_g[i] || d !== exp_g[i]) begin
        bad++;
        $display("FAIL wrap_job%0d: grant=%b done=%b required %b", i, g, d, exp_g[i]);
      end
    end
    req = 3'd0;
  endtask
  task automatic test_timeout();
    do_reset();
    req = 3'b010;
    do_job(-1);
    req = 3'd0;
    total++;
    if (cycles != 17 || d !== 3'b010 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout: cycles=%0d done=%b terr=%b required 17/010/1", cycles, d, timeout_err);
    end
    req = 3'b001;
    do_job(2);
    req = 3'd0;
    total++;
    if (d !== 3'b001 || timeout_err !== 1'b1 || blk_count !== 16'd2) begin
      bad++;
      $display("FAIL timeout_sticky: done=%b terr=%b cnt=%0d required 001/1/2", d, timeout_err, blk_count);
    end
    do_reset();
    tick();
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: terr=%b required 0", timeout_err);
    end
  endtask
  task automatic test_reset_mid_wait();
    int seen;
    req = 3'b100;
    do_job(1);
    req = 3'b001;
    tick();
    tick();
    tick();
    rst = 1'b0;
    req = 3'd0;
    tick();
    rst = 1'b1;
    total++;
    if (grant !== 3'd0 || sel !== 2'd3 || busy !== 1'b0 || blk_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid: grant=%b sel=%0d busy=%b cnt=%0d required 000/3/0/0", grant, sel, busy, blk_count);
    end
    q_out_enable = 1'b1;
    tick();
    q_out_enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | int'(done != 3'd0) | int'(busy);
      tick();
    end
    total++;
    if (seen != 0 || blk_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_late_qoe: activity=%0d cnt=%0d required 0/0", seen, blk_count);
    end
  endtask
  task automatic test_expiry_race();
    do_reset();
    req = 3'b001;
    do_job(16);
    req = 3'd0;
    total++;
    if (cycles != 17 || d !== 3'b001 || timeout_err !== 1'b0 || blk_count !== 16'd1) begin
      bad++;
      $display("FAIL expiry_race: cycles=%0d done=%b terr=%b cnt=%0d required 17/001/0/1", cycles, d, timeout_err, blk_count);
    end
    q_out_enable = 1'b1;
    tick();
    q_out_enable = 1'b0;
    tick();
    total++;
    if (done !== 3'd0 || busy !== 1'b0 || grant !== 3'd0 || blk_count !== 16'd1 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL stray_qoe: done=%b busy=%b grant=%b cnt=%0d terr=%b required 000/0/000/1/0",
               done, busy, grant, blk_count, timeout_err);
    end
  endtask
  initial begin
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_timeout();
    test_reset_mid_wait();
    test_expiry_race();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
